// File: rtl/memoredf_pkg.sv
// Shared constants and types for the MemorEDF queue consume path.
package memoredf_pkg;

  localparam int QUEUE_DATA_W   = 8;
  localparam int DEFAULT_PERIOD = 16;
  localparam int DEFAULT_BUDGET = 4;

  typedef logic [QUEUE_DATA_W-1:0] queue_data_t;

endpackage

// File: rtl/queue_reader_buf.sv
// Two-entry FIFO decoupling the Queue pop strobe from downstream ready.
module queue_reader_buf
  import memoredf_pkg::*;
#(
  parameter int WIDTH = QUEUE_DATA_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             do_push, do_pop;

  // Guards keep the pointers coherent even if a caller misbehaves.
  assign do_push = push && (occ_q != 2'd2);
  assign do_pop  = pop && (occ_q != 2'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    if (do_push && !do_pop)      occ_d = occ_q + 2'd1;
    else if (!do_push && do_pop) occ_d = occ_q - 2'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign valid = (occ_q != 2'd0);
  assign head  = valid ? mem_q[rd_ptr_q] : '0;
  assign occ   = occ_q;

endmodule

// File: rtl/queue_reader.sv
// Bandwidth-regulated Queue consumer: at most BUDGET pops per PERIOD-cycle window.
module queue_reader
  import memoredf_pkg::*;
#(
  parameter int WIDTH  = QUEUE_DATA_W,
  parameter int PERIOD = DEFAULT_PERIOD,
  parameter int BUDGET = DEFAULT_BUDGET
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       q_empty,
  input  logic [WIDTH-1:0]           q_data,
  output logic                       q_consume,
  output logic                       m_valid,
  output logic [WIDTH-1:0]           m_data,
  input  logic                       m_ready,
  output logic                       throttled,
  output logic [$clog2(BUDGET+1)-1:0] budget_left
);

  localparam int WIN_W = $clog2(PERIOD);
  localparam int BUD_W = $clog2(BUDGET+1);

  generate
    if (PERIOD < 2) begin : g_bad_period
      $error("queue_reader: PERIOD must be at least 2");
    end
    if (BUDGET < 1 || BUDGET > PERIOD) begin : g_bad_budget
      $error("queue_reader: BUDGET must satisfy 1 <= BUDGET <= PERIOD");
    end
  endgenerate

  logic [WIN_W-1:0] win_q, win_d;
  logic [BUD_W-1:0] budget_q, budget_d;
  logic [1:0]       occ;
  logic             pop_ok;
  logic             wrap;

  // Pop decision uses only registered state, never m_ready.
  assign pop_ok    = !q_empty && (budget_q != '0) && (occ != 2'd2);
  assign q_consume = pop_ok && !reset;
  assign throttled = !q_empty && (budget_q == '0) && !reset;
  assign wrap      = (win_q == WIN_W'(PERIOD - 1));

  always_comb begin
    win_d    = win_q + WIN_W'(1);
    budget_d = budget_q;
    // A pop on the wrap edge is charged to the ending window, so reload wins.
    if (wrap) begin
      win_d    = '0;
      budget_d = BUD_W'(BUDGET);
    end else if (q_consume) begin
      budget_d = budget_q - BUD_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_q    <= '0;
      budget_q <= BUD_W'(BUDGET);
    end else begin
      win_q    <= win_d;
      budget_q <= budget_d;
    end
  end

  queue_reader_buf #(.WIDTH(WIDTH)) u_buf (
    .clock     (clock),
    .reset     (reset),
    .push      (q_consume),
    .push_data (q_data),
    .pop       (m_valid && m_ready),
    .head      (m_data),
    .valid     (m_valid),
    .occ       (occ)
  );

  assign budget_left = budget_q;

endmodule

// File: tb/tb_queue_reader.sv
// Randomized self-checking bench for queue_reader against a transaction-level model.
module tb_queue_reader;

  localparam int WIDTH  = 8;
  localparam int PERIOD = 16;
  localparam int BUDGET = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             q_empty = 1'b1;
  logic [WIDTH-1:0] q_data = '0;
  logic             q_consume;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready = 1'b0;
  logic             throttled;
  logic [2:0]       budget_left;

  queue_reader #(.WIDTH(WIDTH), .PERIOD(PERIOD), .BUDGET(BUDGET)) dut (
    .clock       (clock),
    .reset       (reset),
    .q_empty     (q_empty),
    .q_data      (q_data),
    .q_consume   (q_consume),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .throttled   (throttled),
    .budget_left (budget_left)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int src[$];      // Queue contents, head at index 0
  int strm[$];     // popped but not yet transferred, in order
  int cyc;
  int pops_win;
  int pop_count;
  int xfer_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_queue();
    q_empty = (src.size() == 0);
    if (q_empty) q_data = WIDTH'($urandom);
    else         q_data = WIDTH'(src[0]);
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic do_cycle(input logic rdy);
    int  e_bud, e_data;
    bit  e_cons, e_valid, e_xfer, e_thr;
    m_ready = rdy;
    drive_queue();
    @(negedge clock);
    e_bud   = BUDGET - pops_win;
    e_cons  = (src.size() > 0) && (e_bud > 0) && (strm.size() < 2);
    e_thr   = (src.size() > 0) && (e_bud == 0);
    e_valid = (strm.size() > 0);
    e_data  = e_valid ? strm[0] : 0;
    e_xfer  = e_valid && rdy;
    check("q_consume",   32'(q_consume),   32'(e_cons));
    check("throttled",   32'(throttled),   32'(e_thr));
    check("budget_left", 32'(budget_left), 32'(e_bud));
    check("m_valid",     32'(m_valid),     32'(e_valid));
    check("m_data",      32'(m_data),      32'(e_data));
    if (q_consume) pop_count++;
    $display("cyc=%0d rdy=%0b cons=%0b valid=%0b data=%02h budget=%0d thr=%0b",
             cyc, rdy, q_consume, m_valid, m_data, budget_left, throttled);
    @(posedge clock);
    if (e_xfer) begin
      void'(strm.pop_front());
      xfer_count++;
    end
    if (e_cons) strm.push_back(src.pop_front());
    if (e_cons) pops_win++;
    cyc++;
    if (cyc % PERIOD == 0) pops_win = 0;
    #1;
  endtask

  // Asynchronous reset pulse in the middle of a cycle; Queue contents survive.
  task automatic apply_reset();
    drive_queue();
    #1 reset = 1'b1;
    #1;
    check("rst_m_valid",   32'(m_valid),     32'd0);
    check("rst_m_data",    32'(m_data),      32'd0);
    check("rst_budget",    32'(budget_left), 32'(BUDGET));
    check("rst_q_consume", 32'(q_consume),   32'd0);
    check("rst_throttled", 32'(throttled),   32'd0);
    $display("reset pulse: valid=%0b data=%02h budget=%0d", m_valid, m_data, budget_left);
    #1 reset = 1'b0;
    strm.delete();
    cyc = 0;
    pops_win = 0;
  endtask

  initial begin
    int base;
    @(posedge clock);
    #1;
    apply_reset();

    // 1: three entries stream out back to back
    src = '{8'h11, 8'h22, 8'h33};
    pop_count = 0;
    for (int i = 0; i < 6; i++) do_cycle(1'b1);
    check("t1_pops", 32'(pop_count), 32'd3);
    check("t1_drained", 32'(m_valid), 32'd0);

    // 2: budget limits a long burst to 4 pops per window
    apply_reset();
    src.delete();
    for (int i = 0; i < 10; i++) src.push_back(8'h40 + i);
    pop_count = 0;
    for (int i = 0; i < PERIOD; i++) do_cycle(1'b1);
    check("t2_window_pops", 32'(pop_count), 32'(BUDGET));
    for (int i = 0; i < 4; i++) do_cycle(1'b1);
    check("t2_resumed_pops", 32'(pop_count), 32'(2 * BUDGET));

    // 3: backpressure stops popping at two entries, then drains in order
    apply_reset();
    src = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    pop_count = 0;
    for (int i = 0; i < 6; i++) do_cycle(1'b0);
    check("t3_held_pops", 32'(pop_count), 32'd2);
    check("t3_held_data", 32'(m_data), 32'hA1);
    xfer_count = 0;
    for (int i = 0; i < 24; i++) do_cycle(1'b1);
    check("t3_xfers", 32'(xfer_count), 32'd5);

    // 4: pop on the wrap edge with one pop left; reload must win
    apply_reset();
    src = '{8'hC1, 8'hC2, 8'hC3};
    for (int i = 0; i < PERIOD + 2; i++) begin
      if (i == PERIOD - 1) src.push_back(8'hC4);
      do_cycle(1'b1);
      if (i == PERIOD - 1) check("t4_budget_after_wrap", 32'(budget_left), 32'(BUDGET));
    end

    // 5: empty Queue with noisy q_data does nothing
    apply_reset();
    src.delete();
    for (int i = 0; i < 8; i++) do_cycle($urandom_range(0, 1) == 1);

    // 6: async reset with a full buffer and one pop left
    apply_reset();
    src = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
    do_cycle(1'b1);
    do_cycle(1'b1);
    do_cycle(1'b0);
    do_cycle(1'b0);
    check("t6_pre_budget", 32'(budget_left), 32'd1);
    check("t6_pre_valid",  32'(m_valid),     32'd1);
    apply_reset();
    base = pop_count;
    do_cycle(1'b1);
    check("t6_first_pop", 32'(pop_count - base), 32'd1);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if (src.size() < 6 && $urandom_range(0, 2) == 0) src.push_back($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) apply_reset();
      do_cycle($urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
